// File: rtl/sim_boot_sequencer.sv
// sim_boot_sequencer: boot-and-health sequencer for the bring-up harness.
// Latches an IP select, holds the DUT in reset, lets it settle, then counts
// activity edges on a set of monitored pad lines over a fixed run window and
// reports pass/fail. Supports per-line masking, abort and restart.

// Per-line conditioning: two-flop synchroniser plus one history flop.
module sim_boot_mon_sync (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic mon,
    input  logic en,
    output logic hit
);
    // pipe[1:0] synchronise the pad, pipe[2] holds the previous synced sample
    logic [2:0] pipe;

    // Shift the pad value through the synchroniser and history stage
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) pipe <= '0;
        else        pipe <= {pipe[1:0], mon};
    end

    // Rising and falling edges both count; masked lines never report
    assign hit = (pipe[2] ^ pipe[1]) & en;
endmodule

module sim_boot_sequencer #(
    parameter int unsigned RST_HOLD_CYC = 10,
    parameter int unsigned SETTLE_CYC   = 100,
    parameter int unsigned RUN_CYC      = 1000,
    parameter int unsigned MIN_EDGES    = 4,
    parameter int unsigned SEL_W        = 3,
    parameter int unsigned NUM_MON      = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [SEL_W-1:0]   ip_sel_cfg_i,
    input  logic [NUM_MON-1:0] mon_mask_i,
    input  logic [NUM_MON-1:0] mon_i,
    output logic [SEL_W-1:0]   ip_sel_o,
    output logic               dut_rst_n_o,
    output logic               busy_o,
    output logic               pass_o,
    output logic               fail_o,
    output logic [2:0]         state_o,
    output logic [CNT_W-1:0]   edge_cnt_o,
    output logic [CNT_W-1:0]   cyc_cnt_o
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HOLD   = 3'd1,
        SETTLE = 3'd2,
        RUN    = 3'd3,
        PASS   = 3'd4,
        FAIL   = 3'd5
    } state_t;

    // Cycle counts compare against "last cycle" values, so a window of N
    // cycles covers cyc_cnt 0..N-1.
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(RUN_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_CNT     = CNT_W'(MIN_EDGES);

    state_t             state, state_nxt;
    logic               start_ok;
    logic [NUM_MON-1:0] mask;
    logic [NUM_MON-1:0] hit;
    logic [CNT_W-1:0]   cyc_cnt;
    logic [CNT_W-1:0]   edge_cnt;
    logic [CNT_W:0]     sum_wide;
    logic [CNT_W-1:0]   edge_sum;

    // Number of lines that reported an edge this cycle
    function automatic logic [CNT_W:0] popcount(input logic [NUM_MON-1:0] v);
        logic [CNT_W:0] n;
        n = '0;
        for (int i = 0; i < NUM_MON; i++) n = n + (CNT_W+1)'(v[i]);
        return n;
    endfunction

    for (genvar g = 0; g < NUM_MON; g++) begin : g_mon
        sim_boot_mon_sync u_sync (
            .sys_clk (sys_clk),
            .rst_n   (rst_n),
            .mon     (mon_i[g]),
            .en      (mask[g]),
            .hit     (hit[g])
        );
    end

    // Running count including this cycle's edges, saturated. Used both to
    // update edge_cnt in RUN and to decide pass/fail on the last RUN cycle,
    // so edges landing on that final cycle still count.
    assign sum_wide = {1'b0, edge_cnt} + popcount(hit);
    assign edge_sum = sum_wide[CNT_W] ? CNT_MAX : sum_wide[CNT_W-1:0];

    // Next-state and state-decoded outputs; abort outranks window expiry
    always_comb begin
        state_nxt   = state;
        start_ok    = 1'b0;
        dut_rst_n_o = 1'b0;
        busy_o      = 1'b0;
        pass_o      = 1'b0;
        fail_o      = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    start_ok  = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                busy_o = 1'b1;
                if (abort_i)                   state_nxt = FAIL;
                else if (cyc_cnt == HOLD_LAST) state_nxt = SETTLE;
            end
            SETTLE: begin
                dut_rst_n_o = 1'b1;
                busy_o      = 1'b1;
                if (abort_i)                     state_nxt = FAIL;
                else if (cyc_cnt == SETTLE_LAST) state_nxt = RUN;
            end
            RUN: begin
                dut_rst_n_o = 1'b1;
                busy_o      = 1'b1;
                if (abort_i)                  state_nxt = FAIL;
                else if (cyc_cnt == RUN_LAST) state_nxt = (edge_sum >= MIN_CNT) ? PASS : FAIL;
            end
            PASS: begin
                dut_rst_n_o = 1'b1;
                pass_o      = 1'b1;
                if (start_i) begin
                    start_ok  = 1'b1;
                    state_nxt = HOLD;
                end
            end
            FAIL: begin
                dut_rst_n_o = 1'b1;
                fail_o      = 1'b1;
                if (start_i) begin
                    start_ok  = 1'b1;
                    state_nxt = HOLD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Cycles spent in the current state; restarts on any change, saturates
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n)                  cyc_cnt <= '0;
        else if (state_nxt != state) cyc_cnt <= '0;
        else if (cyc_cnt != CNT_MAX) cyc_cnt <= cyc_cnt + CNT_W'(1);
    end

    // Edge accumulator: cleared on start, only advances in RUN, frozen after
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n)            edge_cnt <= '0;
        else if (start_ok)     edge_cnt <= '0;
        else if (state == RUN) edge_cnt <= edge_sum;
    end

    // Configuration is captured only on an accepted start and held until the next one
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ip_sel_o <= '0;
            mask     <= '0;
        end else if (start_ok) begin
            ip_sel_o <= ip_sel_cfg_i;
            mask     <= mon_mask_i;
        end
    end

    assign state_o    = state;
    assign edge_cnt_o = edge_cnt;
    assign cyc_cnt_o  = cyc_cnt;
endmodule

// File: tb/tb_sim_boot_sequencer.sv
// Bench for sim_boot_sequencer: table of directed runs, hand-written corner
// sequences (small-counter saturation, async reset mid-run) and randomized
// runs checked against a window-arithmetic reference model.
module tb_sim_boot_sequencer;
    localparam int H         = 10;
    localparam int S         = 100;
    localparam int R         = 1000;
    localparam int RUN_FIRST = 1 + H + S;       // first RUN cycle after start
    localparam int RUN_LAST  = H + S + R;       // last RUN cycle
    localparam int LEN       = RUN_LAST + 26;   // cycles per run
    localparam logic [2:0] ST_IDLE = 3'd0, ST_HOLD = 3'd1, ST_SETTLE = 3'd2,
                           ST_RUN = 3'd3, ST_PASS = 3'd4, ST_FAIL = 3'd5;

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start   = 1'b0;
    logic       abort   = 1'b0;
    logic [2:0] ip_sel_cfg = '0;
    logic [1:0] mon_mask   = '0;
    logic [1:0] mon        = '0;

    logic [2:0]  a_ip_sel, a_state, b_ip_sel, b_state, c_ip_sel, c_state;
    logic        a_dut_rst_n, a_busy, a_pass, a_fail;
    logic        b_dut_rst_n, b_busy, b_pass, b_fail;
    logic        c_dut_rst_n, c_busy, c_pass, c_fail;
    logic [31:0] a_edge, a_cyc, b_edge, b_cyc;
    logic [3:0]  c_edge, c_cyc;

    logic       c_start = 1'b0;
    logic       c_abort = 1'b0;
    logic [2:0] c_sel   = '0;
    logic [1:0] c_mask  = '0;
    logic [1:0] c_mon   = '0;

    int n_pass  = 0;
    int n_total = 0;

    logic [1:0] tog [LEN];

    typedef struct {
        logic [2:0] sel;
        logic [1:0] msk;
        logic [1:0] lines;
        int         first;
        int         period;
        int         count;
        int         abort_t;
        int         restart_t;
        int         exp_edge;
        logic [2:0] exp_a;
        logic [2:0] exp_b;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    always #5 sys_clk = ~sys_clk;

    sim_boot_sequencer u_a (
        .sys_clk(sys_clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
        .ip_sel_cfg_i(ip_sel_cfg), .mon_mask_i(mon_mask), .mon_i(mon),
        .ip_sel_o(a_ip_sel), .dut_rst_n_o(a_dut_rst_n), .busy_o(a_busy),
        .pass_o(a_pass), .fail_o(a_fail), .state_o(a_state),
        .edge_cnt_o(a_edge), .cyc_cnt_o(a_cyc)
    );

    sim_boot_sequencer #(.MIN_EDGES(3)) u_b (
        .sys_clk(sys_clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
        .ip_sel_cfg_i(ip_sel_cfg), .mon_mask_i(mon_mask), .mon_i(mon),
        .ip_sel_o(b_ip_sel), .dut_rst_n_o(b_dut_rst_n), .busy_o(b_busy),
        .pass_o(b_pass), .fail_o(b_fail), .state_o(b_state),
        .edge_cnt_o(b_edge), .cyc_cnt_o(b_cyc)
    );

    sim_boot_sequencer #(.RST_HOLD_CYC(2), .SETTLE_CYC(3), .RUN_CYC(16),
                         .MIN_EDGES(4), .CNT_W(4)) u_c (
        .sys_clk(sys_clk), .rst_n(rst_n), .start_i(c_start), .abort_i(c_abort),
        .ip_sel_cfg_i(c_sel), .mon_mask_i(c_mask), .mon_i(c_mon),
        .ip_sel_o(c_ip_sel), .dut_rst_n_o(c_dut_rst_n), .busy_o(c_busy),
        .pass_o(c_pass), .fail_o(c_fail), .state_o(c_state),
        .edge_cnt_o(c_edge), .cyc_cnt_o(c_cyc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Cycle (relative to the start pulse) at which the run reaches its final state
    function automatic int fin_of(input int abort_t);
        return (abort_t >= 1 && abort_t <= RUN_LAST) ? abort_t + 1 : RUN_LAST + 1;
    endfunction

    function automatic logic [2:0] exp_state(input int t, input int fin_t, input logic [2:0] fin_st);
        if (t >= fin_t) return fin_st;
        if (t <= H)     return ST_HOLD;
        if (t <= H + S) return ST_SETTLE;
        return ST_RUN;
    endfunction

    function automatic int entry_cyc(input int t, input int fin_t);
        if (t >= fin_t) return fin_t;
        if (t <= H)     return 1;
        if (t <= H + S) return H + 1;
        return H + S + 1;
    endfunction

    // A toggle driven in cycle t is seen as an edge in cycle t+2 and counts
    // if that cycle is a RUN cycle before the run ended.
    function automatic int model_edges(input logic [1:0] msk, input int fin_t);
        int n;
        n = 0;
        for (int t = 0; t < LEN; t++)
            if (t + 2 >= RUN_FIRST && t + 2 <= fin_t - 1)
                for (int l = 0; l < 2; l++)
                    if (tog[t][l] && msk[l]) n++;
        return n;
    endfunction

    task automatic do_run(input logic [2:0] sel, input logic [1:0] msk, input int abort_t,
                          input int restart_t, input int exp_edge, input logic [2:0] exp_a,
                          input logic [2:0] exp_b, input string tag);
        int fin_t;
        logic [2:0] es;
        fin_t = fin_of(abort_t);
        for (int t = 0; t < LEN; t++) begin
            @(posedge sys_clk);
            #1;
            start      = (t == 0) || (t == restart_t);
            abort      = (t == abort_t);
            ip_sel_cfg = (t == 0) ? sel : 3'($urandom);
            mon_mask   = (t == 0) ? msk : 2'($urandom);
            mon        = mon ^ tog[t];
            if (t == 1 || t == H || t == H + 1 || t == H + S || t == H + S + 1 ||
                t == RUN_LAST || t == fin_t || t == LEN - 1) begin
                @(negedge sys_clk);
                es = exp_state(t, fin_t, exp_a);
                chk({tag, " state"}, 32'(a_state), 32'(es));
                chk({tag, " cyc_cnt"}, a_cyc, 32'(t - entry_cyc(t, fin_t)));
                chk({tag, " dut_rst_n"}, 32'(a_dut_rst_n), 32'(es != ST_HOLD));
                chk({tag, " busy"}, 32'(a_busy), 32'(es == ST_HOLD || es == ST_SETTLE || es == ST_RUN));
                chk({tag, " ip_sel"}, 32'(a_ip_sel), 32'(sel));
                if (t == 1) chk({tag, " edge cleared"}, a_edge, 0);
            end
        end
        chk({tag, " edge_cnt"}, a_edge, 32'(exp_edge));
        chk({tag, " pass"}, 32'(a_pass), 32'(exp_a == ST_PASS));
        chk({tag, " fail"}, 32'(a_fail), 32'(exp_a == ST_FAIL));
        chk({tag, " min3 state"}, 32'(b_state), 32'(exp_b));
        chk({tag, " min3 edge_cnt"}, b_edge, 32'(exp_edge));
    endtask

    task automatic rand_run(input int r);
        logic [2:0] sel, ea, eb;
        logic [1:0] msk;
        int ab, rs, fin, n, nt;
        sel = 3'($urandom);
        msk = 2'($urandom);
        for (int t = 0; t < LEN; t++) tog[t] = '0;
        for (int l = 0; l < 2; l++) begin
            nt = $urandom_range(0, 6);
            repeat (nt) tog[$urandom_range(100, LEN - 11)][l] = 1'b1;
        end
        ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, LEN - 1)) : -1;
        fin = fin_of(ab);
        rs  = (fin > 2) ? int'($urandom_range(2, fin - 1)) : -1;
        n   = model_edges(msk, fin);
        ea  = (fin == RUN_LAST + 1 && n >= 4) ? ST_PASS : ST_FAIL;
        eb  = (fin == RUN_LAST + 1 && n >= 3) ? ST_PASS : ST_FAIL;
        do_run(sel, msk, ab, rs, n, ea, eb, $sformatf("rand%0d", r));
    endtask

    initial begin
        vecs[0] = '{3'd1, 2'b01, 2'b01, 120,   50, 20,   -1, 500, 20, ST_PASS, ST_PASS};
        vecs[1] = '{3'd5, 2'b01, 2'b01, 200,  100,  3,   -1,  -1,  3, ST_FAIL, ST_PASS};
        vecs[2] = '{3'd2, 2'b10, 2'b01, 200,   50, 10,   -1,  -1,  0, ST_FAIL, ST_FAIL};
        vecs[3] = '{3'd7, 2'b11, 2'b11, 300,  100,  2,   -1,  -1,  4, ST_PASS, ST_PASS};
        vecs[4] = '{3'd3, 2'b01, 2'b01, 150,   50, 10,   50,  30,  0, ST_FAIL, ST_FAIL};
        vecs[5] = '{3'd4, 2'b00, 2'b11, 200,   10, 30,   -1,  -1,  0, ST_FAIL, ST_FAIL};
        vecs[6] = '{3'd6, 2'b01, 2'b01, 108, 1000,  2,   -1,  -1,  1, ST_FAIL, ST_FAIL};
        vecs[7] = '{3'd6, 2'b10, 2'b10, 109, 1000,  2,   -1,  -1,  1, ST_FAIL, ST_FAIL};
        vecs[8] = '{3'd0, 2'b01, 2'b01, 200,   50, 10, 1110,  -1, 10, ST_FAIL, ST_FAIL};

        // Reset values while rst_n is held low
        #2;
        chk("rst state", 32'(a_state), 32'(ST_IDLE));
        chk("rst dut_rst_n", 32'(a_dut_rst_n), 0);
        chk("rst ip_sel", 32'(a_ip_sel), 0);
        chk("rst flags", 32'({a_busy, a_pass, a_fail}), 0);
        chk("rst edge_cnt", a_edge, 0);
        chk("rst cyc_cnt", a_cyc, 0);
        chk("rst small state", 32'(c_state), 32'(ST_IDLE));
        #10;
        rst_n = 1'b1;

        // Small counters: both lines toggling together, saturation at 15
        c_mask = 2'b11;
        for (int t = 0; t < 46; t++) begin
            @(posedge sys_clk);
            #1;
            c_start = (t == 0);
            if (t >= 4 && t <= 13) c_mon = ~c_mon;
            if (t == 7 || t == 9 || t == 16 || t == 22 || t == 23 || t == 43) begin
                @(negedge sys_clk);
                case (t)
                    7:  chk("small two per cycle", 32'(c_edge), 2);
                    9:  chk("small three cycles", 32'(c_edge), 6);
                    16: chk("small saturated", 32'(c_edge), 15);
                    22: chk("small pass state", 32'(c_state), 32'(ST_PASS));
                    23: chk("small edge frozen", 32'(c_edge), 15);
                    default: chk("small cyc_cnt sat", 32'(c_cyc), 15);
                endcase
            end
        end

        // Directed table
        for (int i = 0; i < NVEC; i++) begin
            for (int t = 0; t < LEN; t++) tog[t] = '0;
            for (int k = 0; k < vecs[i].count; k++)
                if (vecs[i].first + k * vecs[i].period < LEN)
                    tog[vecs[i].first + k * vecs[i].period] =
                        tog[vecs[i].first + k * vecs[i].period] | vecs[i].lines;
            do_run(vecs[i].sel, vecs[i].msk, vecs[i].abort_t, vecs[i].restart_t,
                   vecs[i].exp_edge, vecs[i].exp_a, vecs[i].exp_b, $sformatf("vec%0d", i));
        end

        // Asynchronous reset in the middle of RUN
        for (int t = 0; t <= 500; t++) begin
            @(posedge sys_clk);
            #1;
            start      = (t == 0);
            abort      = 1'b0;
            ip_sel_cfg = 3'd6;
        end
        #1;
        chk("midrun state", 32'(a_state), 32'(ST_RUN));
        rst_n = 1'b0;
        #1;
        chk("async state", 32'(a_state), 32'(ST_IDLE));
        chk("async dut_rst_n", 32'(a_dut_rst_n), 0);
        chk("async ip_sel", 32'(a_ip_sel), 0);
        chk("async flags", 32'({a_busy, a_pass, a_fail}), 0);
        chk("async edge_cnt", a_edge, 0);
        chk("async cyc_cnt", a_cyc, 0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("post rst idle", 32'(a_state), 32'(ST_IDLE));
        chk("post rst cyc_cnt", a_cyc, 3);
        chk("post rst dut_rst_n", 32'(a_dut_rst_n), 0);

        // Randomized runs against the window model
        for (int r = 0; r < 8; r++) rand_run(r);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
